uart_rx_core: RTL

//  Serial receive stage of the UART; the consumer of the transmit stage's serial output.

---
 rtl/uart_pkg.sv | 8 +
 rtl/uart_rx_core_if.sv | 20 ++
 rtl/uart_rx_fifo.sv | 44 ++++
 rtl/uart_rx_core.sv | 128 ++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receive types and line-level constants
// Provides rx_state_t for the receiver FSM and the START_BIT/STOP_BIT line levels
// used by both the transmitter and the receiver.
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2, COMMIT} rx_state_t;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
endpackage

// File: rtl/uart_rx_core_if.sv
// uart_rx_core_if: processor-side read/status port of the UART receiver
// rd_en, err_clr             : processor -> receiver (pop FIFO head, clear sticky errors)
// data_out, fifo_full/empty  : FIFO head (first-word fall-through) and occupancy flags
// parity_err, frame_err,
// overrun_err, interrupt     : sticky error flags and level interrupt
interface uart_rx_core_if;
  logic       rd_en;
  logic       err_clr;
  logic [7:0] data_out;
  logic       fifo_full;
  logic       fifo_empty;
  logic       parity_err;
  logic       frame_err;
  logic       overrun_err;
  logic       interrupt;
  modport master (output rd_en, err_clr,
                  input  data_out, fifo_full, fifo_empty, parity_err, frame_err, overrun_err, interrupt);
  modport slave  (input  rd_en, err_clr,
                  output data_out, fifo_full, fifo_empty, parity_err, frame_err, overrun_err, interrupt);
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word fall-through FIFO with synchronous active-low reset
// clk, reset      : clock and synchronous active-low reset
// push, din       : write request and data; accepted when not full or when popping in the same cycle
// pop             : read request; ignored when empty
// dout            : head entry, 0 while empty
// full, empty     : occupancy flags derived combinationally from the count
module uart_rx_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic do_push, do_pop;
  assign empty   = cnt_q == '0;
  assign full    = cnt_q == (AW+1)'(DEPTH);
  assign do_pop  = pop & ~empty;
  // a full FIFO still takes a write when the head leaves in the same cycle
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? '0 : mem_q[rd_q];
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= din;
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/uart_rx_core.sv
// uart_rx_core: UART serial receiver with mid-bit sampling, parity/stop checks and receive FIFO
// clk, reset     : clock and synchronous active-low reset
// rx_in          : serial line, idle high
// baud_divisor   : bit period = baud_divisor+1 clk cycles (>= 3)
// parity_sel     : 0 even, 1 odd
// two_stop_bits  : check a second stop bit
// bus            : processor read port, status flags and interrupt (slave side)
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx_in,
  input  logic [11:0]     baud_divisor,
  input  logic            parity_sel,
  input  logic            two_stop_bits,
  uart_rx_core_if.slave   bus
);
  rx_state_t state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic rx_s, rx_prev_q, tick, stop_bad;
  logic [11:0] cnt_q, div_q;
  logic par_q, two_q;
  logic [2:0] idx_q;
  logic [7:0] shreg_q;
  logic perr_q, ferr_q, push_q, fe_set_q;
  logic pe_q, fe_q, ov_q, pe_d, fe_d, ov_d;
  assign rx_s     = sync_q[SYNC_STAGES-1];
  assign tick     = cnt_q == '0;
  assign stop_bad = rx_s != STOP_BIT;
  always_ff @(posedge clk) begin
    if (!reset) sync_q <= '1;
    else sync_q <= {sync_q[SYNC_STAGES-2:0], rx_in};
  end
  // push_q / fe_set_q are raised on entry to COMMIT so they are high exactly for that cycle
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      rx_prev_q <= 1'b1;
      cnt_q     <= '0;
      div_q     <= '0;
      par_q     <= 1'b0;
      two_q     <= 1'b0;
      idx_q     <= '0;
      shreg_q   <= '0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      push_q    <= 1'b0;
      fe_set_q  <= 1'b0;
    end else begin
      rx_prev_q <= rx_s;
      push_q    <= 1'b0;
      fe_set_q  <= 1'b0;
      if (state_q != IDLE) cnt_q <= tick ? div_q : cnt_q - 12'd1;
      case (state_q)
        // only a 1->0 edge arms a frame, so a held break after a frame error cannot re-trigger
        IDLE: if (rx_prev_q && !rx_s) begin
          state_q <= START;
          cnt_q   <= baud_divisor >> 1;
          div_q   <= baud_divisor;
          par_q   <= parity_sel;
          two_q   <= two_stop_bits;
          ferr_q  <= 1'b0;
        end
        START: if (tick) begin
          state_q <= (rx_s == START_BIT) ? DATA : IDLE;
          idx_q   <= '0;
        end
        DATA: if (tick) begin
          shreg_q <= {rx_s, shreg_q[7:1]};
          idx_q   <= idx_q + 3'd1;
          if (idx_q == 3'd7) state_q <= PARITY;
        end
        PARITY: if (tick) begin
          perr_q  <= rx_s ^ (^shreg_q) ^ par_q;
          state_q <= STOP1;
        end
        STOP1: if (tick) begin
          ferr_q   <= stop_bad;
          state_q  <= two_q ? STOP2 : COMMIT;
          push_q   <= !two_q && !stop_bad;
          fe_set_q <= !two_q && stop_bad;
        end
        STOP2: if (tick) begin
          state_q  <= COMMIT;
          push_q   <= !(ferr_q || stop_bad);
          fe_set_q <= ferr_q || stop_bad;
        end
        COMMIT: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  // a same-cycle set wins over err_clr
  always_comb begin
    pe_d = (push_q & perr_q) | (pe_q & ~bus.err_clr);
    fe_d = fe_set_q | (fe_q & ~bus.err_clr);
    ov_d = (push_q & bus.fifo_full & ~bus.rd_en) | (ov_q & ~bus.err_clr);
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      pe_q <= 1'b0;
      fe_q <= 1'b0;
      ov_q <= 1'b0;
    end else begin
      pe_q <= pe_d;
      fe_q <= fe_d;
      ov_q <= ov_d;
    end
  end
  uart_rx_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_q),
    .pop   (bus.rd_en),
    .din   (shreg_q),
    .dout  (bus.data_out),
    .full  (bus.fifo_full),
    .empty (bus.fifo_empty)
  );
  assign bus.parity_err  = pe_q;
  assign bus.frame_err   = fe_q;
  assign bus.overrun_err = ov_q;
  assign bus.interrupt   = ~bus.fifo_empty | pe_q | fe_q | ov_q;
endmodule
